// File: rtl/addr_trace_gen_if.sv
// Configuration and address-stream bundle between a trace generator and its driver/consumer.
// master = generator side, slave = bench/consumer side.
interface addr_trace_gen_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  length;
  logic [LEN_W-1:0]  loop_span;
  logic              hold;
  logic [ADDR_W-1:0] address;
  logic              addr_valid;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  issued;

  modport master (
    input  start, mode, base, stride, length, loop_span, hold,
    output address, addr_valid, busy, done, issued
  );

  modport slave (
    output start, mode, base, stride, length, loop_span, hold,
    input  address, addr_valid, busy, done, issued
  );
endinterface

// File: rtl/addr_trace_gen.sv
// Programmable word-address trace generator: sequential, strided, looping and LFSR
// patterns, one address per non-held cycle, all outputs registered.
module addr_trace_gen #(
  parameter int          ADDR_W    = 32,
  parameter int          LEN_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input logic              clk,
  input logic              reset,
  addr_trace_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  state_t            state, state_d;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q, stride_q;
  logic [LEN_W-1:0]  len_q, span_q;
  logic [ADDR_W-1:0] ptr, pat;
  logic [LEN_W-1:0]  off, off_d;
  logic [31:0]       lfsr, lfsr_d;
  logic [ADDR_W-1:0] address;
  logic              addr_valid, busy, done;
  logic [LEN_W-1:0]  issued;
  logic              accept, issue;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = (bus.length == '0) ? DONE : RUN;
      end
      RUN: if (!bus.hold) begin
        issue = 1'b1;
        if (issued + LEN_W'(1) == len_q) state_d = DONE;
      end
      // DONE spans two cycles: one for the last address to drain, one with done high
      DONE: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat = ptr;
    case (mode_q)
      2'd2:    pat = base_q + ADDR_W'(off);
      2'd3:    pat = ADDR_W'(lfsr);
      default: pat = ptr;
    endcase
    off_d  = (off == span_q - LEN_W'(1)) ? '0 : off + LEN_W'(1);
    lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      span_q     <= LEN_W'(1);
      ptr        <= '0;
      off        <= '0;
      lfsr       <= LFSR_SEED;
      address    <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      issued     <= '0;
    end else begin
      addr_valid <= issue;
      busy       <= (state_d != IDLE);
      done       <= (state == DONE) && !done;
      if (accept) begin
        mode_q   <= bus.mode;
        base_q   <= bus.base;
        stride_q <= bus.stride;
        len_q    <= bus.length;
        span_q   <= (bus.loop_span == '0) ? LEN_W'(1) : bus.loop_span;
        ptr      <= bus.base;
        off      <= '0;
        lfsr     <= LFSR_SEED;
        issued   <= '0;
      end
      if (issue) begin
        address <= pat;
        issued  <= issued + LEN_W'(1);
        ptr     <= ptr + ((mode_q == 2'd1) ? stride_q : ADDR_W'(1));
        off     <= off_d;
        lfsr    <= lfsr_d;
      end
    end
  end

  assign bus.address    = address;
  assign bus.addr_valid = addr_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.issued     = issued;
endmodule

// File: tb/tb_addr_trace_gen.sv
// Self-checking bench for addr_trace_gen: directed scenarios plus randomized runs
// checked against an arithmetic model of each address pattern.
module tb_addr_trace_gen;
  localparam int AW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  addr_trace_gen_if #(.ADDR_W(AW), .LEN_W(LW)) bus();
  addr_trace_gen #(.ADDR_W(AW), .LEN_W(LW), .LFSR_SEED(32'hACE1_2468)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, busy_cnt = 0, dcyc = -1;
  logic [AW-1:0] obs[$];
  int            vcyc[$];
  logic [AW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // outputs sampled mid-cycle
  always @(negedge clk) begin
    if (bus.addr_valid) begin
      obs.push_back(bus.address);
      vcyc.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      dcyc     <= cyc;
    end
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic build_model(input logic [1:0] m, input logic [AW-1:0] b, s,
                             input logic [LW-1:0] len, sp);
    logic [31:0] x;
    int span_e;
    exp_q.delete();
    x = 32'hACE1_2468;
    span_e = (sp == 0) ? 1 : int'(sp);
    for (int i = 0; i < int'(len); i++) begin
      case (m)
        2'd0:    exp_q.push_back(b + AW'(i));
        2'd1:    exp_q.push_back(b + s * AW'(i));
        2'd2:    exp_q.push_back(b + AW'(i % span_e));
        default: begin
          exp_q.push_back(x);
          x = {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
        end
      endcase
    end
  endtask

  // Called at negedge+1; starts a run, scrambles inputs afterwards, waits (bounded) for done.
  task automatic do_run(input logic [1:0] m, input logic [AW-1:0] b, s,
                        input logic [LW-1:0] len, sp, input int hold_at, hold_n,
                        input bit stray, rnd_hold, tail, output int st_edge, output bit to);
    int k, held;
    obs.delete(); vcyc.delete();
    done_cnt = 0; busy_cnt = 0; dcyc = -1;
    bus.mode = m; bus.base = b; bus.stride = s; bus.length = len; bus.loop_span = sp;
    bus.hold = 1'b0; bus.start = 1'b1;
    st_edge = cyc + 1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.mode = 2'($urandom); bus.base = $urandom; bus.stride = $urandom;
    bus.length = LW'($urandom); bus.loop_span = LW'($urandom);
    k = 0; held = 0;
    while (done_cnt == 0 && k < 300) begin
      if (rnd_hold) bus.hold = ($urandom_range(0, 2) == 0);
      else if (obs.size() == hold_at && held < hold_n) begin bus.hold = 1'b1; held++; end
      else bus.hold = 1'b0;
      bus.start = stray && (k == 1 || k == 3);
      @(negedge clk); #1;
      k++;
    end
    bus.hold = 1'b0; bus.start = 1'b0;
    to = (done_cnt == 0);
    if (tail) repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset;
    n_vec++; if (bus.address !== '0) begin n_bad++; $display("FAIL rst_address got %h want 0", bus.address); end
    n_vec++; if (bus.addr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.addr_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
    n_vec++; if (bus.issued !== '0) begin n_bad++; $display("FAIL rst_issued got %0d want 0", bus.issued); end
    reset = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_seq;
    int st; bit to;
    build_model(2'd0, 32'h1000, 0, 20, 0);
    do_run(2'd0, 32'h1000, 0, 20, 0, -1, 0, 0, 0, 1, st, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL seq_timeout got no done want done"); end
    n_vec++; if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL seq_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL seq_addr[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
    if (vcyc.size() == 20) begin
      n_vec++; if (vcyc[0] !== st + 1) begin n_bad++; $display("FAIL seq_latency got %0d want %0d", vcyc[0], st + 1); end
      n_vec++; if (vcyc[19] - vcyc[0] !== 19) begin n_bad++; $display("FAIL seq_burst got %0d want 19", vcyc[19] - vcyc[0]); end
      n_vec++; if (dcyc !== vcyc[19] + 1) begin n_bad++; $display("FAIL seq_done_cyc got %0d want %0d", dcyc, vcyc[19] + 1); end
    end
    n_vec++; if (bus.issued !== 16'd20) begin n_bad++; $display("FAIL seq_issued got %0d want 20", bus.issued); end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL seq_done_cnt got %0d want 1", done_cnt); end
    n_vec++; if (busy_cnt !== 22) begin n_bad++; $display("FAIL seq_busy got %0d want 22", busy_cnt); end
  endtask

  task automatic test_stride;
    int st; bit to;
    build_model(2'd1, 32'hFFFF_FFF0, 32'h10, 3, 0);
    do_run(2'd1, 32'hFFFF_FFF0, 32'h10, 3, 0, -1, 0, 0, 0, 1, st, to);
    n_vec++; if (obs.size() !== 3) begin n_bad++; $display("FAIL stride_count got %0d want 3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL stride_addr[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_loop;
    int st; bit to;
    for (int sp = 3; sp >= 0; sp -= 3) begin
      build_model(2'd2, 32'h200, 0, 7, LW'(sp));
      do_run(2'd2, 32'h200, 0, 7, LW'(sp), -1, 0, 0, 0, 1, st, to);
      n_vec++; if (obs.size() !== 7) begin n_bad++; $display("FAIL loop%0d_count got %0d want 7", sp, obs.size()); end
      for (int i = 0; i < 7 && i < obs.size(); i++) begin
        n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL loop%0d_addr[%0d] got %h want %h", sp, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random;
    int st; bit to;
    build_model(2'd3, 32'h0, 0, 3, 0);
    for (int r = 0; r < 2; r++) begin
      do_run(2'd3, $urandom, $urandom, 3, 0, -1, 0, 0, 0, 1, st, to);
      n_vec++; if (obs.size() !== 3) begin n_bad++; $display("FAIL rnd%0d_count got %0d want 3", r, obs.size()); end
      for (int i = 0; i < 3 && i < obs.size(); i++) begin
        n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_addr[%0d] got %h want %h", r, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_hold_stray;
    int st; bit to;
    build_model(2'd0, 32'h3000, 0, 4, 0);
    do_run(2'd0, 32'h3000, 0, 4, 0, 2, 2, 1, 0, 1, st, to);
    n_vec++; if (obs.size() !== 4) begin n_bad++; $display("FAIL hold_count got %0d want 4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL hold_addr[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
    if (vcyc.size() == 4) begin
      n_vec++; if (vcyc[2] - vcyc[1] !== 3) begin n_bad++; $display("FAIL hold_gap got %0d want 3", vcyc[2] - vcyc[1]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL hold_done_cnt got %0d want 1", done_cnt); end
    n_vec++; if (busy_cnt !== 8) begin n_bad++; $display("FAIL hold_busy got %0d want 8", busy_cnt); end
  endtask

  task automatic test_reset_zero;
    int k, st; bit to;
    obs.delete(); vcyc.delete(); done_cnt = 0;
    bus.mode = 2'd0; bus.base = 32'h40; bus.length = 10; bus.hold = 1'b0; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (obs.size() < 3 && k < 30) begin @(negedge clk); #1; k++; end
    n_vec++; if (obs.size() !== 3) begin n_bad++; $display("FAIL rz_prefix got %0d want 3", obs.size()); end
    reset = 1'b1; #1;
    n_vec++; if (bus.address !== '0) begin n_bad++; $display("FAIL rz_address got %h want 0", bus.address); end
    n_vec++; if (bus.addr_valid !== 1'b0) begin n_bad++; $display("FAIL rz_valid got %b want 0", bus.addr_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rz_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.issued !== '0) begin n_bad++; $display("FAIL rz_issued got %0d want 0", bus.issued); end
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    n_vec++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rz_no_done got %0d want 0", done_cnt); end
    n_vec++; if (obs.size() !== 3) begin n_bad++; $display("FAIL rz_no_more got %0d want 3", obs.size()); end
    do_run(2'd0, 32'h80, 0, 0, 0, -1, 0, 0, 0, 1, st, to);
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
    n_vec++; if (dcyc !== st + 1) begin n_bad++; $display("FAIL zero_done_cyc got %0d want %0d", dcyc, st + 1); end
    n_vec++; if (busy_cnt !== 2) begin n_bad++; $display("FAIL zero_busy got %0d want 2", busy_cnt); end
    n_vec++; if (obs.size() !== 0) begin n_bad++; $display("FAIL zero_valid got %0d want 0", obs.size()); end
    n_vec++; if (bus.issued !== '0) begin n_bad++; $display("FAIL zero_issued got %0d want 0", bus.issued); end
  endtask

  task automatic test_back_to_back;
    int st; bit to;
    do_run(2'd0, 32'h500, 0, 2, 0, -1, 0, 0, 0, 0, st, to);
    // start raised in the done cycle must be dropped
    bus.mode = 2'd0; bus.base = 32'h700; bus.length = 3; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored got busy %b want 0", bus.busy); end
    build_model(2'd0, 32'h900, 0, 3, 0);
    do_run(2'd0, 32'h900, 0, 3, 0, -1, 0, 0, 0, 1, st, to);
    n_vec++; if (obs.size() !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", obs.size()); end
    if (vcyc.size() > 0) begin
      n_vec++; if (vcyc[0] !== st + 1) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", vcyc[0], st + 1); end
    end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_addr[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_runs;
    int st; bit to;
    logic [1:0] m; logic [AW-1:0] b, s; logic [LW-1:0] len, sp;
    for (int r = 0; r < 25; r++) begin
      m = 2'($urandom); b = $urandom; s = $urandom;
      len = LW'($urandom_range(0, 12)); sp = LW'($urandom_range(0, 5));
      build_model(m, b, s, len, sp);
      do_run(m, b, s, len, sp, -1, 0, 1, 1, 1, st, to);
      n_vec++; if (to) begin n_bad++; $display("FAIL rr%0d_timeout got no done want done", r); end
      n_vec++; if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL rr%0d_count got %0d want %0d", r, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        n_vec++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL rr%0d_addr[%0d] m%0d got %h want %h", r, i, m, obs[i], exp_q[i]); end
      end
      n_vec++; if (bus.issued !== len) begin n_bad++; $display("FAIL rr%0d_issued got %0d want %0d", r, bus.issued, len); end
      n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rr%0d_done_cnt got %0d want 1", r, done_cnt); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = '0; bus.base = '0; bus.stride = '0;
    bus.length = '0; bus.loop_span = '0; bus.hold = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    test_reset;
    test_seq;
    test_stride;
    test_loop;
    test_random;
    test_hold_stray;
    test_reset_zero;
    test_back_to_back;
    test_random_runs;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/addr_trace_gen.md
# addr_trace_gen

Programmable memory-address trace generator that sits directly upstream of the direct-mapped cache model and feeds it one word address per accepted cycle. A run is configured with a base address, pattern mode and length; a small FSM then streams addresses with a valid qualifier until the run completes. This lets benches drive sequential, strided, looping and pseudo-random workloads into the cache, then read its hit and miss counters.

## Interface
- ADDR_W, 32, address width; must match the cache address port
- LEN_W, 16, width of length, span and issue counters
- LFSR_SEED, 32'hACE1_2468, LFSR value loaded at each run start; must be nonzero
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  begin a run; sampled only in IDLE
- mode  in  2  0 sequential, 1 strided, 2 loop, 3 random
- base  in  ADDR_W  first address of the run
- stride  in  ADDR_W  increment for mode 1
- length  in  LEN_W  number of addresses to issue
- loop_span  in  LEN_W  loop window size, in words, for mode 2
- hold  in  1  stall; no address is issued in a cycle where hold=1
- address  out  ADDR_W  current word address
- addr_valid  out  1  address is a new trace element this cycle
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- issued  out  LEN_W  addresses issued in the current or last run

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch mode, base, stride, length and loop_span into shadow registers. Load ptr=base, off=0, lfsr=LFSR_SEED and issued=0.
  - If the latched length is 0, go to DONE.
  - Otherwise go to RUN.
- Input changes after start is accepted have no effect on the run.
- RUN, hold=0: drive address from the current pattern and set addr_valid=1. Then:
  - increment issued;
  - advance the pattern;
  - if issued+1 == length, go to DONE.
- RUN, hold=1: addr_valid=0; address, ptr, off, lfsr and issued are all frozen.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in RUN and DONE, with no queuing.
- Pattern per issue:
  - mode 0: address=ptr, then ptr+=1.
  - mode 1: address=ptr, then ptr+=stride.
  - mode 2: address=base+off, then off = (off==span-1) ? 0 : off+1. A loop_span of 0 is treated as 1.
  - mode 3: address=lfsr, then lfsr advances one Galois step using polynomial 0x80200003 (taps 32,22,2,1).
- Arithmetic: all address math wraps modulo 2^ADDR_W with no saturation. issued never exceeds length.
- address holds its last value whenever addr_valid=0. The consumer must sample only when addr_valid=1.
- Reset: state=IDLE, address=0, addr_valid=0, busy=0, done=0, issued=0. lfsr=LFSR_SEED, ptr=0, off=0.
- Reset mid-run aborts immediately: no done pulse, and issued is cleared.

## Timing
- All outputs are registered.
- Start latency: start sampled at edge N. The first addr_valid=1 appears after edge N+1, assuming hold=0 at N+1.
- Steady state, hold=0: one address per cycle, length consecutive valid cycles.
- busy is 1 in RUN and DONE. It rises after edge N and falls on the edge that clears done.
- done is asserted in the cycle immediately after the last addr_valid cycle.
- With length=0: done is asserted after edge N+1 and no addr_valid is ever asserted.
- hold is sampled at each RUN edge. hold high for k cycles inserts exactly k invalid cycles with no skipped or duplicated address.
- The earliest back-to-back start is accepted in the cycle after done, i.e. in IDLE.

## Test plan
- Mode 0, base=0x1000, length=20, hold=0:
  - Expect addresses 0x1000..0x1013 on 20 consecutive valid cycles.
  - Then a done pulse, with issued=20.
  - Downstream cache should show missCount=2 and hitCount=18.
- Mode 1, base=0xFFFF_FFF0, stride=0x10, length=3:
  - Expect 0xFFFF_FFF0, 0x0000_0000, 0x0000_0010 (wrap-around).
- Mode 2, base=0x200, loop_span=3, length=7:
  - Expect 0x200, 0x201, 0x202, 0x200, 0x201, 0x202, 0x200.
  - With loop_span=0, expect seven repeats of 0x200.
- Mode 3, default seed, length=3:
  - Expect 0xACE1_2468 first, then the next two Galois-step values from the reference model.
  - A second run must reproduce the identical sequence.
- Hold and stray start: mode 0, length=4, hold high for 2 cycles after the 2nd address, start pulsed mid-run.
  - Expect exactly 4 valid addresses, in order, with a 2-cycle gap.
  - The mid-run start is ignored: one done pulse only.
- Reset and zero length:
  - Assert reset after the 3rd address of a length=10 run. All outputs must read 0 and there is no done pulse.
  - Then start with length=0. Expect done after edge N+1, busy high for 2 cycles, and addr_valid never asserted.
